// File: rtl/serial_mod_checker.sv
// Serial divisibility checker: keeps the remainder mod DIVISOR of a binary number
// arriving one bit per accepted cycle, MSB- or LSB-first, with optional fixed frames.
module serial_mod_checker #(
    parameter  int DIVISOR   = 5,
    parameter  int LSB_FIRST = 0,
    parameter  int FRAME_LEN = 0,
    parameter  int CNT_W     = 8,
    localparam int RW        = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic             serial_i,
    output logic [RW-1:0]    remainder_o,
    output logic             divisible_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic             done_o
);

    // Handshake: valid_i alone qualifies serial_i; there is no back-pressure, every
    // cycle with valid_i=1 consumes one bit. start_i acts with or without valid_i.

    localparam logic [RW:0]      DIV_T   = (RW+1)'(DIVISOR);
    localparam logic [RW-1:0]    ONE_R   = RW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [RW-1:0]    rem_q, rem_d;
    logic [RW-1:0]    wgt_q, wgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;

    logic             new_num;
    logic [RW-1:0]    base;
    logic [RW-1:0]    w;
    logic [RW:0]      msb_t, msb_r;
    logic [RW:0]      lsb_t, lsb_r;
    logic [RW:0]      wgt_t, wgt_r;

    // Each reduction is a single compare-subtract: all operands stay below 2*DIVISOR.
    always_comb begin
        new_num = start_i | wrap_q;
        base    = new_num ? '0 : rem_q;
        w       = new_num ? ONE_R : wgt_q;

        msb_t = {base, serial_i};
        msb_r = (msb_t >= DIV_T) ? (msb_t - DIV_T) : msb_t;

        lsb_t = {1'b0, base} + (serial_i ? {1'b0, w} : '0);
        lsb_r = (lsb_t >= DIV_T) ? (lsb_t - DIV_T) : lsb_t;

        wgt_t = {w, 1'b0};
        wgt_r = (wgt_t >= DIV_T) ? (wgt_t - DIV_T) : wgt_t;
    end

    always_comb begin
        rem_d  = rem_q;
        wgt_d  = wgt_q;
        cnt_d  = cnt_q;
        wrap_d = wrap_q;
        done_d = 1'b0;

        if (valid_i) begin
            rem_d  = (LSB_FIRST != 0) ? lsb_r[RW-1:0] : msb_r[RW-1:0];
            wgt_d  = wgt_r[RW-1:0];
            wrap_d = 1'b0;
            if (new_num) begin
                cnt_d = ONE_C;
            end else if ((FRAME_LEN == 0) && (cnt_q == CNT_MAX)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + ONE_C;
            end
            // Frame completion: the final result is held while wrap_q waits for the next bit.
            if ((FRAME_LEN != 0) && (cnt_d == FRAME_C)) begin
                done_d = 1'b1;
                wrap_d = 1'b1;
            end
        end else if (start_i) begin
            rem_d  = '0;
            wgt_d  = ONE_R;
            cnt_d  = '0;
            wrap_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            wgt_q  <= ONE_R;
            cnt_q  <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            wgt_q  <= wgt_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
        end
    end

    assign remainder_o = rem_q;
    assign divisible_o = (rem_q == '0);
    assign bit_count_o = cnt_q;
    assign done_o      = done_q;

endmodule
